// File: rtl/procyon_ccu_ifq.sv
// Instruction-fetch miss queue: tracks icache line misses in allocation order,
// issues them to the CCU one at a time and emits a one-cycle fill strobe per line.

module procyon_ccu_ifq_entry #(
  parameter int LA_W = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_we,
  input  logic            pop,
  input  logic [LA_W-1:0] alloc_addr,
  output logic [LA_W-1:0] addr,
  output logic            match
);
  logic valid;

  always_ff @(posedge clk) begin
    if (rst)           valid <= 1'b0;
    else if (alloc_we) valid <= 1'b1;
    else if (pop)      valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (alloc_we) addr <= alloc_addr;
  end

  assign match = valid && (addr == alloc_addr);
endmodule

module procyon_ccu_ifq #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_IC_LINE_SIZE = 32,
  parameter int OPTN_IFQ_DEPTH    = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   i_alloc_en,
  input  logic [OPTN_ADDR_WIDTH-$clog2(OPTN_IC_LINE_SIZE)-1:0]   i_alloc_addr,
  output logic                                                   o_ifq_full,
  output logic                                                   o_ccu_en,
  output logic [OPTN_ADDR_WIDTH-$clog2(OPTN_IC_LINE_SIZE)-1:0]   o_ccu_addr,
  input  logic                                                   i_ccu_done,
  input  logic [8*OPTN_IC_LINE_SIZE-1:0]                         i_ccu_data,
  output logic                                                   o_fill_en,
  output logic [OPTN_ADDR_WIDTH-$clog2(OPTN_IC_LINE_SIZE)-1:0]   o_fill_addr,
  output logic [8*OPTN_IC_LINE_SIZE-1:0]                         o_fill_data
);
  localparam int IC_LINE_WIDTH   = 8*OPTN_IC_LINE_SIZE;
  localparam int IC_OFFSET_WIDTH = $clog2(OPTN_IC_LINE_SIZE);
  localparam int LA_W            = OPTN_ADDR_WIDTH - IC_OFFSET_WIDTH;
  localparam int IDX_W           = $clog2(OPTN_IFQ_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                             state, state_next;
  logic [IDX_W-1:0]                   head, tail;
  logic [IDX_W:0]                     count;
  logic [OPTN_IFQ_DEPTH-1:0]          entry_match;
  logic [OPTN_IFQ_DEPTH-1:0][LA_W-1:0] entry_addr;
  logic                               alloc_accept, pop_en;
  logic [LA_W-1:0]                    fill_addr;
  logic [IC_LINE_WIDTH-1:0]           fill_data;

  assign o_ifq_full = (count == (IDX_W+1)'(OPTN_IFQ_DEPTH));
  // Duplicate check covers every valid entry, including the head being filled.
  assign alloc_accept = i_alloc_en && !o_ifq_full && !(|entry_match);

  for (genvar g = 0; g < OPTN_IFQ_DEPTH; g++) begin : g_entry
    procyon_ccu_ifq_entry #(.LA_W(LA_W)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .alloc_we   (alloc_accept && (tail == IDX_W'(g))),
      .pop        (pop_en && (head == IDX_W'(g))),
      .alloc_addr (i_alloc_addr),
      .addr       (entry_addr[g]),
      .match      (entry_match[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_ccu_en   = 1'b0;
    o_fill_en  = 1'b0;
    pop_en     = 1'b0;
    case (state)
      IDLE: if (count != '0) state_next = REQ;
      REQ: begin
        o_ccu_en = 1'b1;
        if (i_ccu_done) state_next = FILL;
      end
      FILL: begin
        o_fill_en  = 1'b1;
        pop_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_accept) tail <= tail + 1'b1;
      if (pop_en)       head <= head + 1'b1;
      count <= count + {{IDX_W{1'b0}}, alloc_accept} - {{IDX_W{1'b0}}, pop_en};
    end
  end

  // Head entry cannot be overwritten while it is outstanding, so the address is stable in REQ.
  assign o_ccu_addr = entry_addr[head];

  always_ff @(posedge clk) begin
    if (!rst && (state == REQ) && i_ccu_done) begin
      fill_addr <= entry_addr[head];
      fill_data <= i_ccu_data;
    end
  end

  assign o_fill_addr = fill_addr;
  assign o_fill_data = fill_data;
endmodule

// File: tb/tb_procyon_ccu_ifq.sv
// Bench for procyon_ccu_ifq: directed vector table, corner-case sequences,
// and randomized traffic checked against a queue-based reference model.

module tb_procyon_ccu_ifq;
  localparam int LA    = 27;
  localparam int LW    = 256;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_alloc_en = 1'b0;
  logic [LA-1:0] i_alloc_addr = '0;
  logic          i_ccu_done = 1'b0;
  logic [LW-1:0] i_ccu_data = '0;
  logic          o_ifq_full, o_ccu_en, o_fill_en;
  logic [LA-1:0] o_ccu_addr, o_fill_addr;
  logic [LW-1:0] o_fill_data;

  procyon_ccu_ifq dut (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .o_ifq_full   (o_ifq_full),
    .o_ccu_en     (o_ccu_en),
    .o_ccu_addr   (o_ccu_addr),
    .i_ccu_done   (i_ccu_done),
    .i_ccu_data   (i_ccu_data),
    .o_fill_en    (o_fill_en),
    .o_fill_addr  (o_fill_addr),
    .o_fill_data  (o_fill_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending misses in allocation order plus the current protocol phase.
  logic [LA-1:0] mq[$];
  int            mphase = 0; // 0 waiting, 1 requesting, 2 filling
  logic [LA-1:0] m_fill_addr;
  logic [LW-1:0] m_fill_data;
  bit            m_have_fill = 0;
  logic [LA-1:0] ccu_log[$];
  logic          prev_ccu_en = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic a_en, input logic [LA-1:0] a,
                              input logic d, input logic [LW-1:0] data);
    bit dup;
    bit acc;
    int sz;
    dup = 0;
    if (r) begin
      mq.delete();
      mphase = 0;
    end else begin
      foreach (mq[k]) if (mq[k] == a) dup = 1;
      sz  = mq.size();
      acc = a_en && (sz < DEPTH) && !dup;
      case (mphase)
        0: if (sz > 0) mphase = 1;
        1: if (d) begin
             m_fill_addr = mq[0];
             m_fill_data = data;
             m_have_fill = 1;
             mphase = 2;
           end
        default: begin
          void'(mq.pop_front());
          mphase = 0;
        end
      endcase
      if (acc) mq.push_back(a);
    end
  endtask

  task automatic model_check();
    chk("full", o_ifq_full, mq.size() == DEPTH);
    chk("ccu_en", o_ccu_en, mphase == 1);
    if (mphase == 1) chk("ccu_addr", o_ccu_addr, mq[0]);
    chk("fill_en", o_fill_en, mphase == 2);
    if (m_have_fill) begin
      chk("fill_addr", o_fill_addr, m_fill_addr);
      chk("fill_data", o_fill_data, m_fill_data);
    end
    if (o_ccu_en && !prev_ccu_en) ccu_log.push_back(o_ccu_addr);
    prev_ccu_en = o_ccu_en;
  endtask

  task automatic step(input logic r, input logic a_en, input logic [LA-1:0] a,
                      input logic d, input logic [LW-1:0] data);
    rst = r; i_alloc_en = a_en; i_alloc_addr = a; i_ccu_done = d; i_ccu_data = data;
    @(posedge clk);
    model_update(r, a_en, a, d, data);
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);
    ccu_log.delete();
  endtask

  typedef struct {
    logic          r;
    logic          a_en;
    logic [LA-1:0] a;
    logic          d;
    logic          e_full;
    logic          e_ccu;
    logic [LA-1:0] e_ccu_addr;
    logic          e_fill;
    logic [LA-1:0] e_fill_addr;
  } vec_t;

  vec_t          tbl[9];
  logic [LW-1:0] dpat;
  logic [LW-1:0] rdata;
  int            n77;

  initial begin
    dpat = {8{32'hC0FFEE11}};
    //          r  aen addr     d  full ccu addr     fill faddr
    tbl[0] = '{0, 1, 27'h1234, 0, 0,   0,  27'h0,    0,   27'h0};
    tbl[1] = '{0, 0, 27'h0,    0, 0,   1,  27'h1234, 0,   27'h0};
    tbl[2] = '{0, 0, 27'h0,    0, 0,   1,  27'h1234, 0,   27'h0};
    tbl[3] = '{0, 0, 27'h0,    0, 0,   1,  27'h1234, 0,   27'h0};
    tbl[4] = '{0, 0, 27'h0,    0, 0,   1,  27'h1234, 0,   27'h0};
    tbl[5] = '{0, 0, 27'h0,    1, 0,   0,  27'h0,    1,   27'h1234};
    tbl[6] = '{0, 0, 27'h0,    0, 0,   0,  27'h0,    0,   27'h0};
    tbl[7] = '{0, 0, 27'h0,    1, 0,   0,  27'h0,    0,   27'h0};
    tbl[8] = '{0, 0, 27'h0,    0, 0,   0,  27'h0,    0,   27'h0};

    // Reset state and single-miss latency
    do_reset();
    chk("rst_full", o_ifq_full, 0);
    chk("rst_ccu_en", o_ccu_en, 0);
    chk("rst_fill_en", o_fill_en, 0);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].a_en, tbl[i].a, tbl[i].d, dpat);
      chk($sformatf("tbl%0d_full", i), o_ifq_full, tbl[i].e_full);
      chk($sformatf("tbl%0d_ccu_en", i), o_ccu_en, tbl[i].e_ccu);
      if (tbl[i].e_ccu) chk($sformatf("tbl%0d_ccu_addr", i), o_ccu_addr, tbl[i].e_ccu_addr);
      chk($sformatf("tbl%0d_fill_en", i), o_fill_en, tbl[i].e_fill);
      if (tbl[i].e_fill) begin
        chk($sformatf("tbl%0d_fill_addr", i), o_fill_addr, tbl[i].e_fill_addr);
        chk($sformatf("tbl%0d_fill_data", i), o_fill_data, dpat);
      end
    end

    // Fill to capacity, drop on full, wrap into slot 0 after the first pop
    do_reset();
    step(0, 1, 27'h10, 0, '0);
    step(0, 1, 27'h20, 0, '0);
    step(0, 1, 27'h30, 0, '0);
    step(0, 1, 27'h40, 0, '0);
    chk("wrap_full", o_ifq_full, 1);
    step(0, 1, 27'h50, 0, '0);
    step(0, 0, '0, 1, dpat);
    step(0, 0, '0, 0, '0);
    chk("wrap_after_pop", o_ifq_full, 0);
    step(0, 1, 27'h50, 0, '0);
    chk("wrap_refull", o_ifq_full, 1);
    for (int k = 0; k < 40; k++) step(0, 0, '0, 1, dpat);
    chk("wrap_nreq", ccu_log.size(), 5);
    for (int k = 0; k < 5 && k < ccu_log.size(); k++)
      chk($sformatf("wrap_order%0d", k), ccu_log[k], LA'(32'h10 * (k + 1)));

    // Duplicate allocations, including during the fill of that line
    do_reset();
    step(0, 1, 27'h77, 0, '0);
    step(0, 1, 27'h77, 0, '0);
    step(0, 0, '0, 1, dpat);
    step(0, 1, 27'h77, 0, '0);
    idle(6);
    n77 = 0;
    foreach (ccu_log[k]) if (ccu_log[k] == 27'h77) n77++;
    chk("dup_nreq", n77, 1);
    chk("dup_total", ccu_log.size(), 1);

    // Alloc during FILL with a full queue: dropped
    do_reset();
    step(0, 1, 27'h1, 0, '0);
    step(0, 1, 27'h2, 0, '0);
    step(0, 1, 27'h3, 0, '0);
    step(0, 1, 27'h4, 0, '0);
    step(0, 0, '0, 1, dpat);
    step(0, 1, 27'h99, 0, '0);
    chk("simfull_after", o_ifq_full, 0);
    step(0, 1, 27'h5, 0, '0);
    chk("simfull_count3", o_ifq_full, 1);

    // Alloc during FILL with room: accepted, count unchanged
    do_reset();
    step(0, 1, 27'h1, 0, '0);
    step(0, 1, 27'h2, 0, '0);
    step(0, 0, '0, 1, dpat);
    step(0, 1, 27'h99, 0, '0);
    step(0, 1, 27'h3, 0, '0);
    chk("simroom_3", o_ifq_full, 0);
    step(0, 1, 27'h4, 0, '0);
    chk("simroom_4", o_ifq_full, 1);

    // Reset while a request is outstanding
    do_reset();
    step(0, 1, 27'hA0, 0, '0);
    step(0, 1, 27'hB0, 0, '0);
    step(0, 0, '0, 0, '0);
    chk("midrst_inreq", o_ccu_en, 1);
    step(1, 0, '0, 1, dpat);
    chk("midrst_ccu_en", o_ccu_en, 0);
    chk("midrst_full", o_ifq_full, 0);
    step(0, 0, '0, 1, dpat);
    chk("midrst_nofill0", o_fill_en, 0);
    step(0, 0, '0, 1, dpat);
    chk("midrst_nofill1", o_fill_en, 0);
    idle(3);
    chk("midrst_idle", o_ccu_en, 0);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int w = 0; w < 8; w++) rdata[w*32 +: 32] = $urandom();
      step($urandom_range(199) == 0, $urandom_range(1), LA'(32'h100 + $urandom_range(7)),
           $urandom_range(9) < 3, rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
